// File: rtl/int4_weight_unpacker.sv
// int4_weight_unpacker: holds one packed INT4 weight word and streams it out
// as LANES unsigned nibbles per beat, lowest nibbles first, to the int2fp16
// lane column. Single-word holding stage with valid/ready on both sides.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_EMPTY | no word held; s_ready high (outside reset/clr)
// ST_HOLD  | word held; r_beat_cnt selects the beat currently on m_nib
//
// WORD_W must be a multiple of 4*LANES.
module int4_weight_unpacker #(
  parameter int WORD_W = 32,
  parameter int LANES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [4*LANES-1:0]   m_nib,
  output logic                 m_last,
  output logic                 busy
);

  localparam int NIB_W = 4 * LANES;
  localparam int BEATS = WORD_W / NIB_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [WORD_W-1:0]   r_hold_data;
  logic                r_hold_last;

  logic                w_hold_valid;
  logic                w_last_beat;
  logic                w_xfer;
  logic                w_accept;

  assign w_hold_valid = (r_state == ST_HOLD);
  assign w_last_beat  = (r_beat_cnt == LAST_CNT);
  assign w_xfer       = w_hold_valid & m_ready;

  // A new word may land on the same edge the final beat leaves, so a
  // continuously fed stream runs without bubbles. rst_n gates s_ready
  // combinationally so nothing upstream sees ready during reset.
  assign s_ready  = rst_n & ~clr & (~w_hold_valid | (m_ready & w_last_beat));
  assign w_accept = s_valid & s_ready;

  // Beat data is a pure nibble slice of the held word; no arithmetic.
  assign m_valid = w_hold_valid;
  assign busy    = w_hold_valid;
  assign m_nib   = r_hold_data[NIB_W*r_beat_cnt +: NIB_W];
  assign m_last  = w_hold_valid & r_hold_last & w_last_beat;

  // Holding FSM: clear beats accept, accept (reload) beats beat advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_beat_cnt  <= '0;
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
    end else if (clr) begin
      r_state     <= ST_EMPTY;
      r_beat_cnt  <= '0;
      r_hold_last <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_HOLD;
      r_beat_cnt  <= '0;
      r_hold_data <= s_data;
      r_hold_last <= s_last;
    end else if (w_xfer) begin
      if (w_last_beat) begin
        r_state    <= ST_EMPTY;
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_int4_weight_unpacker.sv
// Bench for int4_weight_unpacker: directed table, hand sequences for the
// multi-cycle corners, and a randomized run against a beat-queue model.
module tb_int4_weight_unpacker;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_nib;
  logic        m_last;
  logic        busy;

  logic        u8_clr;
  logic        u8_s_valid;
  logic        u8_s_ready;
  logic [31:0] u8_s_data;
  logic        u8_s_last;
  logic        u8_m_valid;
  logic        u8_m_ready;
  logic [31:0] u8_m_nib;
  logic        u8_m_last;
  logic        u8_busy;

  int n_tests = 0;
  int n_fail  = 0;

  int4_weight_unpacker #(.WORD_W(32), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_nib(m_nib), .m_last(m_last),
    .busy(busy)
  );

  int4_weight_unpacker #(.WORD_W(32), .LANES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(u8_clr),
    .s_valid(u8_s_valid), .s_ready(u8_s_ready), .s_data(u8_s_data), .s_last(u8_s_last),
    .m_valid(u8_m_valid), .m_ready(u8_m_ready), .m_nib(u8_m_nib), .m_last(u8_m_last),
    .busy(u8_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic        last;
    int          stall;
  } vec_t;

  vec_t vecs[5];

  typedef struct {
    logic [15:0] nib;
    logic        last;
  } beat_t;

  beat_t q[$];

  initial begin : main
    logic [31:0] w;
    logic [15:0] b0, b1;
    logic        exp_rdy;

    rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    u8_clr = 1'b0; u8_s_valid = 1'b0; u8_s_data = '0; u8_s_last = 1'b0; u8_m_ready = 1'b0;

    vecs[0] = '{32'h7654_3210, 1'b1, 0};
    vecs[1] = '{32'h7654_3210, 1'b0, 3};
    vecs[2] = '{32'hA5A5_0F0F, 1'b1, 1};
    vecs[3] = '{32'hFFFF_0000, 1'b0, 0};
    vecs[4] = '{32'h0001_8000, 1'b1, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_nib",   {16'd0, m_nib},   32'd0);
    chk("rst_m_last",  {31'd0, m_last},  32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", {31'd0, s_ready}, 32'd1);

    // Table: single words with optional beat0 backpressure
    foreach (vecs[i]) begin
      w  = vecs[i].word;
      b0 = w[15:0];
      b1 = w[31:16];
      @(negedge clk);
      s_valid = 1'b1; s_data = w; s_last = vecs[i].last; m_ready = 1'b1;
      #1;
      chk("tbl_s_ready_idle", {31'd0, s_ready}, 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
      if (vecs[i].stall > 0) begin
        m_ready = 1'b0;
        for (int k = 0; k < vecs[i].stall; k++) begin
          #1;
          chk("stall_nib",     {16'd0, m_nib},   {16'd0, b0});
          chk("stall_valid",   {31'd0, m_valid}, 32'd1);
          chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
          @(negedge clk);
        end
        m_ready = 1'b1;
      end
      #1;
      chk("tbl_beat0_nib",  {16'd0, m_nib},  {16'd0, b0});
      chk("tbl_beat0_last", {31'd0, m_last}, 32'd0);
      @(negedge clk);
      #1;
      chk("tbl_beat1_nib",  {16'd0, m_nib},  {16'd0, b1});
      chk("tbl_beat1_last", {31'd0, m_last}, {31'd0, vecs[i].last});
      @(negedge clk);
      #1;
      chk("tbl_done_valid", {31'd0, m_valid}, 32'd0);
      chk("tbl_done_ready", {31'd0, s_ready}, 32'd1);
    end

    // Back-to-back words, no bubble
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'hFEDC_BA98; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    s_data = 32'h1111_2222; s_last = 1'b1;
    #1;
    chk("b2b_beat0", {16'd0, m_nib}, 32'h0000_BA98);
    chk("b2b_rdy0",  {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("b2b_beat1", {16'd0, m_nib}, 32'h0000_FEDC);
    chk("b2b_rdy1",  {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("b2b_beat2", {16'd0, m_nib}, 32'h0000_2222);
    chk("b2b_valid2", {31'd0, m_valid}, 32'd1);
    @(negedge clk);
    #1;
    chk("b2b_beat3", {16'd0, m_nib}, 32'h0000_1111);
    chk("b2b_last3", {31'd0, m_last}, 32'd1);
    @(negedge clk);
    #1;
    chk("b2b_end_valid", {31'd0, m_valid}, 32'd0);

    // clr while beat1 pending, with a word offered
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h7654_3210; s_last = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'hAAAA_BBBB; clr = 1'b1;
    #1;
    chk("clr_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    clr = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    #1;
    chk("clr_m_valid", {31'd0, m_valid}, 32'd0);
    chk("clr_busy",    {31'd0, busy},    32'd0);
    chk("clr_m_last",  {31'd0, m_last},  32'd0);
    s_valid = 1'b1; s_data = 32'h1234_5678; s_last = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("clr_next_beat0", {16'd0, m_nib}, 32'h0000_5678);
    @(negedge clk);
    #1;
    chk("clr_next_beat1", {16'd0, m_nib}, 32'h0000_1234);
    @(negedge clk);

    // Async reset mid-word
    s_valid = 1'b1; s_data = 32'h9ABC_DEF0; s_last = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_m_nib",   {16'd0, m_nib},   32'd0);
    chk("arst_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'h4321_8765; s_last = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("arst_restart_beat0", {16'd0, m_nib}, 32'h0000_8765);
    @(negedge clk);
    #1;
    chk("arst_restart_beat1", {16'd0, m_nib}, 32'h0000_4321);
    @(negedge clk);

    // LANES=8: whole word in one beat, then single-entry register behaviour
    u8_s_valid = 1'b1; u8_s_data = 32'hCAFE_F00D; u8_s_last = 1'b1; u8_m_ready = 1'b1;
    @(negedge clk);
    u8_s_data = 32'h0BAD_BEEF; u8_s_last = 1'b0; u8_m_ready = 1'b0;
    #1;
    chk("l8_nib",   u8_m_nib, 32'hCAFE_F00D);
    chk("l8_last",  {31'd0, u8_m_last}, 32'd1);
    chk("l8_stall_rdy", {31'd0, u8_s_ready}, 32'd0);
    @(negedge clk);
    u8_m_ready = 1'b1;
    #1;
    chk("l8_stall_nib", u8_m_nib, 32'hCAFE_F00D);
    chk("l8_pass_rdy",  {31'd0, u8_s_ready}, 32'd1);
    @(negedge clk);
    u8_s_valid = 1'b0;
    #1;
    chk("l8_second", u8_m_nib, 32'h0BAD_BEEF);
    chk("l8_second_last", {31'd0, u8_m_last}, 32'd0);
    @(negedge clk);
    #1;
    chk("l8_empty", {31'd0, u8_m_valid}, 32'd0);

    // Randomized run against a queue of expected beats
    @(negedge clk);
    clr = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 9) < 6);
      s_data  = $urandom;
      s_last  = $urandom_range(0, 1);
      m_ready = ($urandom_range(0, 9) < 7);
      clr     = ($urandom_range(0, 39) == 0);
      #1;
      exp_rdy = ~clr & ((q.size() == 0) | (m_ready & (q.size() == 1)));
      chk("rnd_s_ready", {31'd0, s_ready}, {31'd0, exp_rdy});
      chk("rnd_m_valid", {31'd0, m_valid}, {31'd0, q.size() != 0});
      chk("rnd_busy",    {31'd0, busy},    {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("rnd_m_nib",  {16'd0, m_nib},  {16'd0, q[0].nib});
        chk("rnd_m_last", {31'd0, m_last}, {31'd0, q[0].last});
      end else begin
        chk("rnd_m_last_idle", {31'd0, m_last}, 32'd0);
      end
      if (clr) begin
        q.delete();
      end else begin
        if (q.size() != 0 && m_ready) void'(q.pop_front());
        if (s_valid && exp_rdy) begin
          for (int b = 0; b < 2; b++) begin
            beat_t nb;
            nb.nib  = 16'(s_data >> (16 * b));
            nb.last = s_last && (b == 1);
            q.push_back(nb);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
